shiftreg_ctrl: RTL and testbench

SHIFTREG_CTRL -- requirements
Module: shiftreg_ctrl

---
 rtl/shiftreg_ctrl.sv | 111 +++++++++++
 tb/tb_shiftreg_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_ctrl.sv
// Controller for a universal shift register: parallel-load a word, shift it N times, report the result.
// Optional macro SHIFTREG_CTRL_ROTATE_EN turns the serial fill into a rotate of the register contents.
module shiftreg_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  output logic [1:0]       sr_sel,
  output logic [WIDTH-1:0] sr_val,
  output logic             sr_din,
  input  logic [WIDTH-1:0] sr_dout,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             dir_q;
  logic             fill_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] res_hold;
  logic             shift_bit;

  // The shift count is latched straight into remaining; LOAD decides whether any shifting is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      dir_q     <= 1'b0;
      fill_q    <= 1'b0;
      data_q    <= '0;
      res_hold  <= '0;
      sr_sel    <= SEL_HOLD;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          res_valid <= 1'b0;
          if (cmd_valid) begin
            dir_q     <= cmd_dir;
            fill_q    <= cmd_fill;
            data_q    <= cmd_data;
            remaining <= cmd_count;
            state     <= LOAD;
            sr_sel    <= SEL_LOAD;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (remaining != '0) begin
            state  <= SHIFT;
            sr_sel <= dir_q ? SEL_LEFT : SEL_RIGHT;
          end else begin
            state     <= DONE;
            sr_sel    <= SEL_HOLD;
            res_valid <= 1'b1;
          end
        end
        SHIFT: begin
          remaining <= remaining - 1'b1;
          if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state     <= DONE;
            sr_sel    <= SEL_HOLD;
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          res_hold  <= sr_dout;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          sr_sel    <= SEL_HOLD;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHIFTREG_CTRL_ROTATE_EN
  assign shift_bit = dir_q ? sr_dout[WIDTH-1] : sr_dout[0];
`else
  assign shift_bit = fill_q;
`endif

  // The final shift lands on the edge entering DONE, so the result is passed through live in DONE.
  assign res_data  = res_valid ? sr_dout : res_hold;
  assign cmd_ready = (state == IDLE) && !rst;
  assign sr_val    = data_q;
  assign sr_din    = (state == SHIFT) ? shift_bit : 1'b0;

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// Self-checking bench for shiftreg_ctrl with a behavioural 4-bit universal shift register attached.
module tb_shiftreg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [3:0] cmd_data;
  logic [2:0] cmd_count;
  logic       cmd_fill;
  logic [1:0] sr_sel;
  logic [3:0] sr_val;
  logic       sr_din;
  logic [3:0] sr_dout;
  logic       res_valid;
  logic [3:0] res_data;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  shiftreg_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
    .sr_sel(sr_sel), .sr_val(sr_val), .sr_din(sr_din), .sr_dout(sr_dout),
    .res_valid(res_valid), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference shift register driven by the controller's select lines.
  initial sr_dout = 4'b0000;
  always @(posedge clk) begin
    case (sr_sel)
      2'b01:   sr_dout <= {sr_din, sr_dout[3:1]};
      2'b10:   sr_dout <= {sr_dout[2:0], sr_din};
      2'b11:   sr_dout <= sr_val;
      default: sr_dout <= sr_dout;
    endcase
  end

  typedef struct {
    logic       dir;
    logic [3:0] data;
    logic [2:0] count;
    logic       fill;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offers one command from IDLE and follows it until res_valid (bounded), noting what was seen.
  task automatic apply_stimulus(input vec_t v, output int lat, output logic saw_shift,
                                output logic [1:0] first_sel, output logic din_bad,
                                output logic [3:0] data_at_valid);
    logic first;
    lat = -1; saw_shift = 1'b0; first_sel = 2'b00; din_bad = 1'b0; data_at_valid = 4'h0;
    first = 1'b1;
    @(negedge clk);
    cmd_dir = v.dir; cmd_data = v.data; cmd_count = v.count; cmd_fill = v.fill;
    cmd_valid = 1'b1;
    check_output("ready_in_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_output("load_sel", sr_sel, 2'b11);
    check_output("load_val", sr_val, v.data);
    check_output("load_busy", busy, 1);
    check_output("load_ready", cmd_ready, 0);
    for (int c = 2; c < 40; c++) begin
      @(negedge clk);
      if (sr_sel == 2'b01 || sr_sel == 2'b10) begin
        saw_shift = 1'b1;
        if (first) first_sel = sr_sel;
        first = 1'b0;
`ifndef SHIFTREG_CTRL_ROTATE_EN
        if (sr_din !== v.fill) din_bad = 1'b1;
`endif
      end else if (sr_din !== 1'b0) begin
        din_bad = 1'b1;
      end
      if (res_valid) begin
        lat = c;
        data_at_valid = res_data;
        break;
      end
    end
  endtask

  int         lat;
  logic       saw_shift;
  logic [1:0] first_sel;
  logic       din_bad;
  logic [3:0] got;

  initial begin
    vecs[0] = '{dir: 1'b0, data: 4'b1100, count: 3'd1, fill: 1'b0, exp: 4'b0110};
    vecs[1] = '{dir: 1'b1, data: 4'b1100, count: 3'd2, fill: 1'b1, exp: 4'b0011};
    vecs[2] = '{dir: 1'b0, data: 4'b1010, count: 3'd0, fill: 1'b0, exp: 4'b1010};
`ifdef SHIFTREG_CTRL_ROTATE_EN
    vecs[3] = '{dir: 1'b0, data: 4'b1100, count: 3'd2, fill: 1'b1, exp: 4'b0011};
    vecs[4] = '{dir: 1'b1, data: 4'b1011, count: 3'd4, fill: 1'b0, exp: 4'b1011};
    vecs[5] = '{dir: 1'b0, data: 4'b0001, count: 3'd7, fill: 1'b1, exp: 4'b0010};
`else
    vecs[3] = '{dir: 1'b0, data: 4'b1100, count: 3'd2, fill: 1'b1, exp: 4'b1111};
    vecs[4] = '{dir: 1'b1, data: 4'b1011, count: 3'd4, fill: 1'b0, exp: 4'b0000};
    vecs[5] = '{dir: 1'b0, data: 4'b0001, count: 3'd7, fill: 1'b1, exp: 4'b1111};
`endif

    rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_data = 4'h0; cmd_count = 3'd0; cmd_fill = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_ready", cmd_ready, 0);
    check_output("rst_sel", sr_sel, 2'b00);
    check_output("rst_busy", busy, 0);
    check_output("rst_res_valid", res_valid, 0);
    check_output("rst_res_data", res_data, 4'h0);
    check_output("rst_din", sr_din, 0);
    check_output("rst_val", sr_val, 4'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i], lat, saw_shift, first_sel, din_bad, got);
      check_output($sformatf("latency_v%0d", i), lat, vecs[i].count + 2);
      check_output($sformatf("result_v%0d", i), got, vecs[i].exp);
      check_output($sformatf("din_v%0d", i), din_bad, 0);
      if (vecs[i].count == 0)
        check_output($sformatf("no_shift_v%0d", i), saw_shift, 0);
      else
        check_output($sformatf("shift_dir_v%0d", i), first_sel, vecs[i].dir ? 2'b10 : 2'b01);
      @(negedge clk);
      check_output($sformatf("pulse_end_v%0d", i), res_valid, 0);
      check_output($sformatf("idle_ready_v%0d", i), cmd_ready, 1);
      check_output($sformatf("idle_busy_v%0d", i), busy, 0);
      check_output($sformatf("hold_v%0d", i), res_data, vecs[i].exp);
    end

    // Reset during the second SHIFT cycle of a count=3 command.
    @(negedge clk);
    cmd_dir = 1'b0; cmd_data = 4'b1001; cmd_count = 3'd3; cmd_fill = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_output("abort_in_shift", sr_sel, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    check_output("abort_sel", sr_sel, 2'b00);
    check_output("abort_busy", busy, 0);
    check_output("abort_ready_in_rst", cmd_ready, 0);
    check_output("abort_res_data", res_data, 4'h0);
    rst = 1'b0;
    @(negedge clk);
    check_output("abort_ready_after", cmd_ready, 1);
    saw_shift = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (res_valid || busy || sr_sel != 2'b00) saw_shift = 1'b1;
      @(negedge clk);
    end
    check_output("abort_quiet", saw_shift, 0);

    // Backpressure: cmd_valid held high with count=1 accepts every fourth cycle.
    cmd_dir = 1'b0; cmd_data = 4'b0101; cmd_count = 3'd1; cmd_fill = 1'b0; cmd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      check_output($sformatf("bp_ready_c%0d", c), cmd_ready, (c % 4) == 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
